// File: rtl/module_serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor step per clock.
// start_i/a_i/b_i in; busy_o/done_o handshake; diff_o/borrow_o/overflow_o out.
module module_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             d;
  logic             br_next;
  logic             last;

  assign d       = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0])
                 | (~a_q[0] & br_q)
                 | (b_q[0] & br_q);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  // New bit enters at the MSB; written this way so WIDTH=1 needs no slice.
  assign res_next = (res_q >> 1)
                  | (WIDTH'(d) << (WIDTH - 1));

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      br_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_o     <= '0;
      borrow_o   <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE) && start_i: begin
          a_q     <= a_i;
          b_q     <= b_i;
          br_q    <= 1'b0;
          cnt_q   <= '0;
          a_msb_q <= a_i[WIDTH-1];
          b_msb_q <= b_i[WIDTH-1];
        end
        state_q == RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_next;
          br_q  <= br_next;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            diff_o     <= res_next;
            borrow_o   <= br_next;
            // d of the last step is the result sign bit.
            overflow_o <= (a_msb_q ^ b_msb_q)
                        & (d ^ a_msb_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_module_serial_subtractor.sv
// Bench for module_serial_subtractor (WIDTH=8): table vectors,
// corner sequences and random operands against an arithmetic model.
module tb_module_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] prev_diff = '0;
  logic       prev_br   = 1'b0;
  logic       prev_ov   = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  vec_t tbl[7];
  op_t  q[$];

  module_serial_subtractor #(.WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .a_i        (a_in),
    .b_i        (b_in),
    .busy_o     (busy),
    .done_o     (done),
    .diff_o     (diff),
    .borrow_o   (borrow),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    vec_t r;
    int   sd;
    r.a  = a;
    r.b  = b;
    r.d  = 8'((int'(a) - int'(b)) & 255);
    r.br = (a < b);
    sd   = int'($signed(a)) - int'($signed(b));
    r.ov = (sd > 127) || (sd < -128);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int inj, input string nm);
    int cyc;
    int nb;
    @(negedge clk);
    start = 1'b1;
    a_in  = v.a;
    b_in  = v.b;
    @(negedge clk);
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    cyc   = 1;
    nb    = 0;
    while (!done && cyc < 20) begin
      if (busy) nb++;
      chk({nm, ".hold"}, {ovf, borrow, diff},
          {prev_ov, prev_br, prev_diff});
      if (cyc == inj) begin
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (busy) nb++;
    chk({nm, ".latency"}, cyc, 9);
    chk({nm, ".busy_cycles"}, nb, 9);
    chk({nm, ".diff"}, diff, v.d);
    chk({nm, ".borrow"}, borrow, v.br);
    chk({nm, ".ovf"}, ovf, v.ov);
    prev_diff = v.d;
    prev_br   = v.br;
    prev_ov   = v.ov;
    @(negedge clk);
    chk({nm, ".done_clr"}, done, 0);
    chk({nm, ".busy_clr"}, busy, 0);
  endtask

  initial begin
    tbl[0] = '{8'h50, 8'h20, 8'h30, 1'b0, 1'b0};
    tbl[1] = '{8'h20, 8'h50, 8'hD0, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[4] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 0);
    chk("rst.borrow", borrow, 0);
    chk("rst.ovf", ovf, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(tbl[i], -1, $sformatf("tbl%0d", i));

    run_op('{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0}, 3, "ign_start");

    // Reset in the middle of RUN, between clock edges.
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'h10;
    b_in  = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.diff", diff, 0);
    chk("arst.borrow", borrow, 0);
    chk("arst.ovf", ovf, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst.no_done", done, 0);
    end
    rst_n     = 1'b1;
    prev_diff = '0;
    prev_br   = 1'b0;
    prev_ov   = 1'b0;
    run_op('{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0}, -1, "post_rst");

    // start held high: an accept every 10 cycles.
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    q.push_back('{a_in, b_in});
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      if (t % 10 == 9) begin
        vec_t m;
        op_t  o;
        chk("b2b.done", done, 1);
        if (q.size() > 0) begin
          o = q.pop_front();
          m = model(o.a, o.b);
          chk("b2b.diff", diff, m.d);
          chk("b2b.borrow", borrow, m.br);
          chk("b2b.ovf", ovf, m.ov);
          prev_diff = m.d;
          prev_br   = m.br;
          prev_ov   = m.ov;
        end
      end else begin
        chk("b2b.no_done", done, 0);
        chk("b2b.hold", {ovf, borrow, diff},
            {prev_ov, prev_br, prev_diff});
      end
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      if (t % 10 == 0 && t < 50) q.push_back('{a_in, b_in});
      if (t == 50) start = 1'b0;
    end
    chk("b2b.drained", q.size(), 0);
    @(negedge clk);

    for (int i = 0; i < 40; i++)
      run_op(model(8'($urandom), 8'($urandom)), -1,
             $sformatf("rnd%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/module_serial_subtractor.md
Name: module_serial_subtractor

Overview:
Bit-serial two's-complement subtractor that computes diff = a - b, LSB first, one bit per clock. Each cycle it applies a 1-bit full-subtractor cell (difference and borrow) and keeps the borrow in a flip-flop. It is the inverse-operation counterpart of the team's 1-bit full adder. It targets area-limited datapaths that can accept WIDTH cycles of latency per operation, and uses a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
clk_i  input  1  system clock; all state updates on the rising edge.
rst_n_i  input  1  asynchronous reset, active-low.
start_i  input  1  request a new subtraction; sampled only in IDLE.
a_i  input  WIDTH  minuend; captured on the accepted start.
b_i  input  WIDTH  subtrahend; captured on the accepted start.
busy_o  output  1  high while an operation is in progress (state RUN or DONE).
done_o  output  1  one-cycle pulse: result outputs are valid and updated.
diff_o  output  WIDTH  result a - b modulo 2^WIDTH.
borrow_o  output  1  final borrow out; 1 iff a < b unsigned.
overflow_o  output  1  signed overflow of a - b.

Behaviour:
- Reset (rst_n_i low, asynchronous): state=IDLE. busy_o, done_o, diff_o, borrow_o, overflow_o all 0. Internal shift registers, borrow FF and bit counter cleared. Reset during RUN aborts the operation with no done_o pulse.
- State machine:
  - IDLE: if start_i=1, latch a_i into shift reg A and b_i into shift reg B, clear borrow FF, clear counter, go to RUN. Otherwise stay.
  - RUN: each edge processes bit k = A[0], B[0] with borrow br:
    - d = A0 ^ B0 ^ br
    - br_next = (~A0 & B0) | (~A0 & br) | (B0 & br)
    - Shift A and B right by one. Shift d into the MSB end of the result shift reg. Increment counter.
    - After the WIDTH-th bit, go to DONE.
  - DONE: for one cycle, done_o=1 and busy_o=1. Then go unconditionally to IDLE.
- Output registers: diff_o, borrow_o and overflow_o load on the RUN->DONE edge and hold until the next RUN->DONE edge.
  - borrow_o = final br.
  - overflow_o = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched operand MSBs.
  - During RUN, the outputs keep the previous result.
- Latency: start sampled at edge E0. done_o is high in the cycle following edge E(WIDTH). Throughput is one operation per WIDTH+2 cycles.
- start_i is ignored in RUN and DONE, with no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- a_i and b_i may change freely after the accepting edge; only the latched copies are used.
- WIDTH=1: RUN lasts one cycle. Overflow is evaluated on the single bit as the sign bit.
- No combinational path from any input to any output.

Test Plan:
1. WIDTH=8: a=0x50, b=0x20, start 1 cycle -> done_o pulses exactly 8 cycles after the start edge; diff_o=0x30, borrow_o=0, overflow_o=0; busy_o high for 9 cycles.
2. a=0x20, b=0x50 -> diff_o=0xD0, borrow_o=1, overflow_o=0. Then a=0x80, b=0x01 -> diff_o=0x7F, borrow_o=0, overflow_o=1.
3. a=0x7F, b=0xFF -> diff_o=0x80, borrow_o=1, overflow_o=1. Then a=b=0xA5 -> diff_o=0x00, borrow_o=0, overflow_o=0.
4. Start accepted with a=0x10, b=0x01. Pulse start_i with a=0xFF, b=0x00 at RUN cycle 3 -> ignored; result is 0x0F; exactly one done_o pulse.
5. Pull rst_n_i low mid-RUN (bit 4), asynchronously between edges -> all outputs 0 immediately, no done_o. After release, a=0x03, b=0x05 -> diff_o=0xFE, borrow_o=1.
6. Back-to-back: hold start_i high continuously with changing operands -> a new operation is accepted every 10 cycles. Each done_o carries the result of the operands latched at its own start. Outputs are stable between pulses.
